// File: rtl/efuse_ctrl.sv
// Sequencer for the LN05LPE 10k x 40b eFUSE wrapper: turns read/program commands into
// CSB/LOAD/PGENB/PSM/STROBE timing and returns exactly one response per command.
module efuse_ctrl #(
    parameter int unsigned EFUSE_ADDR_W = 14,
    parameter int unsigned EFUSE_DEPTH  = 10240,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned RD_STRB_CYC  = 4,
    parameter int unsigned PG_STRB_CYC  = 200,
    parameter int unsigned PSM_CYC      = 50,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_prog,
    input  logic [EFUSE_ADDR_W-1:0] i_req_addr,
    input  logic                    i_prog_unlock,
    input  logic [1:0]              i_pmr,
    output logic                    o_rsp_valid,
    output logic                    o_rsp_err,
    output logic [39:0]             o_rsp_data,
    output logic                    o_busy,
    output logic                    o_efuse_csb,
    output logic                    o_efuse_strobe,
    output logic                    o_efuse_load,
    output logic                    o_efuse_pgenb,
    output logic                    o_efuse_psm,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_a,
    output logic [1:0]              o_efuse_pmr,
    input  logic [39:0]             i_efuse_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RESP
    } state_t;

    // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_STRB_CYC - 1);
    localparam logic [CNT_W-1:0] PG_LD    = CNT_W'(PG_STRB_CYC - 1);
    localparam logic [CNT_W-1:0] PSM_LD   = CNT_W'(PSM_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    prog_q, prog_d;
    logic                    err_q, err_d;
    logic [39:0]             data_q, data_d;

    logic                    csb_d, strobe_d, load_d, pgenb_d, psm_d;
    logic [EFUSE_ADDR_W-1:0] a_d;
    logic [1:0]              pmr_d;
    logic                    rsp_valid_d, rsp_err_d;
    logic [39:0]             rsp_data_d;

    logic                    accept;
    logic                    bad_cmd;
    logic                    cnt_done;

    assign o_req_ready = (state == S_IDLE) && !i_rst;
    assign o_busy      = (state != S_IDLE);
    assign accept      = i_req_valid && o_req_ready;
    assign cnt_done    = (cnt == '0);
    assign bad_cmd     = (32'(i_req_addr) >= EFUSE_DEPTH) || (i_req_prog && !i_prog_unlock);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            prog_q         <= 1'b0;
            err_q          <= 1'b0;
            data_q         <= '0;
            o_efuse_csb    <= 1'b1;
            o_efuse_strobe <= 1'b0;
            o_efuse_load   <= 1'b1;
            o_efuse_pgenb  <= 1'b1;
            o_efuse_psm    <= 1'b0;
            o_efuse_a      <= '0;
            o_efuse_pmr    <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_err      <= 1'b0;
            o_rsp_data     <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            prog_q         <= prog_d;
            err_q          <= err_d;
            data_q         <= data_d;
            o_efuse_csb    <= csb_d;
            o_efuse_strobe <= strobe_d;
            o_efuse_load   <= load_d;
            o_efuse_pgenb  <= pgenb_d;
            o_efuse_psm    <= psm_d;
            o_efuse_a      <= a_d;
            o_efuse_pmr    <= pmr_d;
            o_rsp_valid    <= rsp_valid_d;
            o_rsp_err      <= rsp_err_d;
            o_rsp_data     <= rsp_data_d;
        end
    end

    // Pin values are computed one cycle ahead so every macro control leaves a flop.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        prog_d      = prog_q;
        err_d       = err_q;
        data_d      = data_q;
        csb_d       = o_efuse_csb;
        strobe_d    = o_efuse_strobe;
        load_d      = o_efuse_load;
        pgenb_d     = o_efuse_pgenb;
        psm_d       = o_efuse_psm;
        a_d         = o_efuse_a;
        pmr_d       = o_efuse_pmr;
        rsp_valid_d = 1'b0;
        rsp_err_d   = o_rsp_err;
        rsp_data_d  = o_rsp_data;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    prog_d = i_req_prog;
                    data_d = '0;
                    if (bad_cmd) begin
                        // Rejected commands never touch the macro pins.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d = 1'b0;
                        a_d   = i_req_addr;
                        pmr_d = i_pmr;
                        csb_d = 1'b0;
                        if (i_req_prog) begin
                            load_d  = 1'b0;
                            psm_d   = 1'b1;
                            pgenb_d = 1'b1;
                            cnt_d   = PSM_LD;
                            state_d = S_PWRUP;
                        end else begin
                            load_d  = 1'b1;
                            psm_d   = 1'b0;
                            pgenb_d = 1'b1;
                            cnt_d   = SETUP_LD;
                            state_d = S_SETUP;
                        end
                    end
                end
            end
            S_PWRUP: begin
                if (cnt_done) begin
                    // PSM has settled; PGENB may now fall with LOAD low and CSB low.
                    pgenb_d = 1'b0;
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    strobe_d = 1'b1;
                    cnt_d    = prog_q ? PG_LD : RD_LD;
                    state_d  = S_STROBE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt_done) begin
                    if (!prog_q) begin
                        data_d = i_efuse_q;
                    end
                    strobe_d = 1'b0;
                    cnt_d    = HOLD_LD;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    csb_d   = 1'b1;
                    load_d  = 1'b1;
                    pgenb_d = 1'b1;
                    psm_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_data_d  = data_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_efuse_ctrl.sv
// Randomized self-checking bench for efuse_ctrl; expected latencies, pin windows and
// read data come from the parameter arithmetic and a behavioural fuse array model.
module tb_efuse_ctrl;

    localparam int AW       = 14;
    localparam int DEPTH    = 10240;
    localparam int SETUP    = 2;
    localparam int RD       = 4;
    localparam int PG       = 200;
    localparam int PSM      = 50;
    localparam int HOLD     = 2;
    localparam int RD_LAT   = SETUP + RD + HOLD + 1;
    localparam int PG_LAT   = PSM + SETUP + PG + HOLD + 1;

    typedef struct {
        int          lat;
        int          strb;
        int          csb_lo;
        int          psm_pre;
        int          pgenb_lo;
        int          viol;
        int          pin_bad;
        int          rdy;
        logic [39:0] data;
        logic        err;
    } obs_t;

    logic          i_clk;
    logic          i_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_prog;
    logic [AW-1:0] i_req_addr;
    logic          i_prog_unlock;
    logic [1:0]    i_pmr;
    logic          o_rsp_valid;
    logic          o_rsp_err;
    logic [39:0]   o_rsp_data;
    logic          o_busy;
    logic          o_efuse_csb;
    logic          o_efuse_strobe;
    logic          o_efuse_load;
    logic          o_efuse_pgenb;
    logic          o_efuse_psm;
    logic [AW-1:0] o_efuse_a;
    logic [1:0]    o_efuse_pmr;
    logic [39:0]   i_efuse_q;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] cur_a;
    logic [1:0]    cur_pmr;

    efuse_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_prog(i_req_prog), .i_req_addr(i_req_addr),
        .i_prog_unlock(i_prog_unlock), .i_pmr(i_pmr),
        .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
        .o_busy(o_busy),
        .o_efuse_csb(o_efuse_csb), .o_efuse_strobe(o_efuse_strobe),
        .o_efuse_load(o_efuse_load), .o_efuse_pgenb(o_efuse_pgenb),
        .o_efuse_psm(o_efuse_psm), .o_efuse_a(o_efuse_a), .o_efuse_pmr(o_efuse_pmr),
        .i_efuse_q(i_efuse_q)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [39:0] fuse_q(input logic [AW-1:0] a);
        if (a == 14'h0123) return 40'hA5_5A5A_5A5A;
        return {a ^ 14'h2A5C, 12'hC3A, a};
    endfunction

    // Macro model: Q is only meaningful while a read strobe is active.
    always_comb begin
        i_efuse_q = 40'h0;
        if (!o_efuse_csb && o_efuse_strobe && o_efuse_load) i_efuse_q = fuse_q(o_efuse_a);
    end

    task automatic issue(input logic prog, input logic [AW-1:0] addr, input logic unlock,
                         input logic [1:0] pmr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        i_req_valid   = 1'b1;
        i_req_prog    = prog;
        i_req_addr    = addr;
        i_prog_unlock = unlock;
        i_pmr         = pmr;
        @(posedge i_clk);
        #1;
    endtask

    // Observes one operation starting right after its accept edge; sample n is n edges later.
    task automatic run_op(input logic [AW-1:0] exp_a, input logic [1:0] exp_pmr, output obs_t o);
        logic [AW-1:0] pa;
        logic          pl, pp, pstr;
        bit            seen_pg;
        o.lat = -1; o.strb = 0; o.csb_lo = 0; o.psm_pre = 0; o.pgenb_lo = 0;
        o.viol = 0; o.pin_bad = 0; o.rdy = 0; o.data = '0; o.err = 1'b0;
        pa = '0; pl = 1'b0; pp = 1'b0; pstr = 1'b0; seen_pg = 1'b0;
        for (int n = 0; n <= 400; n++) begin
            if (n > 0) begin
                @(posedge i_clk);
                #1;
            end
            if (n == 0) i_req_valid = 1'b0;
            if (o_efuse_strobe && o_efuse_csb) o.viol++;
            if (!o_efuse_pgenb && !(!o_efuse_load && o_efuse_psm && !o_efuse_csb)) o.viol++;
            if (o_efuse_strobe && pstr &&
                (o_efuse_a !== pa || o_efuse_load !== pl || o_efuse_pgenb !== pp)) o.viol++;
            pa = o_efuse_a; pl = o_efuse_load; pp = o_efuse_pgenb; pstr = o_efuse_strobe;
            if (o_efuse_strobe) o.strb++;
            if (!o_efuse_csb) o.csb_lo++;
            if (!o_efuse_pgenb) begin
                o.pgenb_lo++;
                seen_pg = 1'b1;
            end
            if (o_efuse_psm && o_efuse_pgenb && !seen_pg) o.psm_pre++;
            if (o_efuse_a !== exp_a || o_efuse_pmr !== exp_pmr) o.pin_bad++;
            if (o_rsp_valid === 1'b1) begin
                o.lat  = n;
                o.data = o_rsp_data;
                o.err  = o_rsp_err;
                break;
            end
            if (o_req_ready === 1'b1) o.rdy++;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_efuse_csb !== 1'b1) begin errors++; $display("FAIL reset_csb got %b want 1", o_efuse_csb); end
        checks++; if (o_efuse_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", o_efuse_strobe); end
        checks++; if (o_efuse_load !== 1'b1) begin errors++; $display("FAIL reset_load got %b want 1", o_efuse_load); end
        checks++; if (o_efuse_pgenb !== 1'b1) begin errors++; $display("FAIL reset_pgenb got %b want 1", o_efuse_pgenb); end
        checks++; if (o_efuse_psm !== 1'b0) begin errors++; $display("FAIL reset_psm got %b want 0", o_efuse_psm); end
        checks++; if (o_efuse_a !== 14'h0) begin errors++; $display("FAIL reset_a got %h want 0", o_efuse_a); end
        checks++; if (o_efuse_pmr !== 2'b00) begin errors++; $display("FAIL reset_pmr got %b want 00", o_efuse_pmr); end
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_req_ready); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
        checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", o_rsp_err); end
        checks++; if (o_rsp_data !== 40'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", o_rsp_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", o_req_ready); end
        cur_a = '0;
        cur_pmr = '0;
    endtask

    task automatic test_read_basic;
        obs_t o;
        bit   ok;
        cur_a = 14'h0123; cur_pmr = 2'b00;
        issue(1'b0, 14'h0123, 1'b0, 2'b00, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_accept got %b want 1", ok); end
        checks++; if (o.lat != RD_LAT) begin errors++; $display("FAIL rd_latency got %0d want %0d", o.lat, RD_LAT); end
        checks++; if (o.data !== 40'hA55A5A5A5A) begin errors++; $display("FAIL rd_data got %h want a55a5a5a5a", o.data); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", o.err); end
        checks++; if (o.strb != RD) begin errors++; $display("FAIL rd_strobe_width got %0d want %0d", o.strb, RD); end
        checks++; if (o.pgenb_lo != 0) begin errors++; $display("FAIL rd_pgenb_low got %0d want 0", o.pgenb_lo); end
        checks++; if (o.csb_lo != RD_LAT - 1) begin errors++; $display("FAIL rd_csb_low got %0d want %0d", o.csb_lo, RD_LAT - 1); end
        checks++; if (o.viol != 0) begin errors++; $display("FAIL rd_invariants got %0d want 0", o.viol); end
        @(posedge i_clk);
        #1;
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_one_cycle got %b want 0", o_rsp_valid); end
    endtask

    task automatic test_program;
        obs_t o;
        bit   ok;
        cur_a = 14'h2000; cur_pmr = 2'b00;
        issue(1'b1, 14'h2000, 1'b1, 2'b00, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.lat != PG_LAT) begin errors++; $display("FAIL pg_latency got %0d want %0d", o.lat, PG_LAT); end
        checks++; if (o.err !== 1'b0 || o.data !== 40'h0) begin errors++; $display("FAIL pg_rsp got err=%b data=%h want 0/0", o.err, o.data); end
        checks++; if (o.psm_pre != PSM) begin errors++; $display("FAIL pg_psm_settle got %0d want %0d", o.psm_pre, PSM); end
        checks++; if (o.strb != PG) begin errors++; $display("FAIL pg_strobe_width got %0d want %0d", o.strb, PG); end
        checks++; if (o.pgenb_lo != SETUP + PG + HOLD) begin errors++; $display("FAIL pg_pgenb_low got %0d want %0d", o.pgenb_lo, SETUP + PG + HOLD); end
        checks++; if (o.csb_lo != PG_LAT - 1) begin errors++; $display("FAIL pg_csb_low got %0d want %0d", o.csb_lo, PG_LAT - 1); end
        checks++; if (o.viol != 0) begin errors++; $display("FAIL pg_invariants got %0d want 0", o.viol); end
        checks++; if (o.rdy != 0) begin errors++; $display("FAIL pg_ready_while_busy got %0d want 0", o.rdy); end
        @(posedge i_clk);
        #1;
        checks++; if (o_efuse_psm !== 1'b0 || o_efuse_pgenb !== 1'b1) begin errors++; $display("FAIL pg_idle_pins got psm=%b pgenb=%b want 0/1", o_efuse_psm, o_efuse_pgenb); end
    endtask

    task automatic test_errors;
        obs_t o;
        bit   ok;
        issue(1'b1, 14'h0100, 1'b0, 2'b11, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.lat != 1 || o.err !== 1'b1 || o.data !== 40'h0) begin errors++; $display("FAIL locked_prog got lat=%0d err=%b data=%h want 1/1/0", o.lat, o.err, o.data); end
        checks++; if (o.csb_lo != 0 || o.pin_bad != 0) begin errors++; $display("FAIL locked_prog_pins got csb_lo=%0d pin_bad=%0d want 0/0", o.csb_lo, o.pin_bad); end
        issue(1'b0, 14'(DEPTH), 1'b1, 2'b01, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.lat != 1 || o.err !== 1'b1 || o.data !== 40'h0) begin errors++; $display("FAIL oob_read got lat=%0d err=%b data=%h want 1/1/0", o.lat, o.err, o.data); end
        checks++; if (o.csb_lo != 0 || o.pin_bad != 0) begin errors++; $display("FAIL oob_read_pins got csb_lo=%0d pin_bad=%0d want 0/0", o.csb_lo, o.pin_bad); end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] addrs [3];
        int            acc_t [$];
        int            rsp_t [$];
        logic [39:0]   rsp_d [$];
        int            nacc;
        for (int i = 0; i < 3; i++) addrs[i] = 14'($urandom_range(DEPTH - 1));
        i_req_prog = 1'b0; i_prog_unlock = 1'b0; i_pmr = 2'b00;
        nacc = 0;
        for (int t = 0; t < 45; t++) begin
            @(posedge i_clk);
            #1;
            if (o_rsp_valid === 1'b1) begin
                rsp_t.push_back(t);
                rsp_d.push_back(o_rsp_data);
            end
            if (nacc < 3) begin
                i_req_valid = 1'b1;
                i_req_addr  = addrs[nacc];
                if (o_req_ready === 1'b1) begin
                    acc_t.push_back(t);
                    nacc++;
                end
            end else begin
                i_req_valid = 1'b0;
            end
        end
        cur_a = addrs[2]; cur_pmr = 2'b00;
        checks++; if (acc_t.size() != 3 || rsp_t.size() != 3) begin errors++; $display("FAIL b2b_counts got acc=%0d rsp=%0d want 3/3", acc_t.size(), rsp_t.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0 && i < acc_t.size()) begin
                checks++; if (acc_t[i] - acc_t[i-1] != RD_LAT + 1) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, acc_t[i] - acc_t[i-1], RD_LAT + 1); end
            end
            if (i < acc_t.size() && i < rsp_t.size()) begin
                checks++; if (rsp_t[i] != acc_t[i] + RD_LAT + 1) begin errors++; $display("FAIL b2b_rsp_time[%0d] got %0d want %0d", i, rsp_t[i], acc_t[i] + RD_LAT + 1); end
                checks++; if (rsp_d[i] !== fuse_q(addrs[i])) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, rsp_d[i], fuse_q(addrs[i])); end
            end
        end
    endtask

    task automatic test_reset_mid_program;
        obs_t o;
        bit   ok;
        int   strb, nrsp;
        issue(1'b1, 14'h1555, 1'b1, 2'b01, ok);
        i_req_valid = 1'b0;
        strb = 0;
        for (int n = 0; n < 300; n++) begin
            if (o_efuse_strobe === 1'b1) strb++;
            if (strb == 100) break;
            @(posedge i_clk);
            #1;
        end
        checks++; if (strb != 100) begin errors++; $display("FAIL rstmid_reach_strobe got %0d want 100", strb); end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checks++; if (o_efuse_strobe !== 1'b0 || o_efuse_pgenb !== 1'b1 || o_efuse_psm !== 1'b0 || o_efuse_csb !== 1'b1)
            begin errors++; $display("FAIL rstmid_pins got strobe=%b pgenb=%b psm=%b csb=%b want 0/1/0/1", o_efuse_strobe, o_efuse_pgenb, o_efuse_psm, o_efuse_csb); end
        checks++; if (o_efuse_load !== 1'b1 || o_efuse_a !== 14'h0 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_state got load=%b a=%h rsp=%b busy=%b want 1/0/0/0", o_efuse_load, o_efuse_a, o_rsp_valid, o_busy); end
        i_rst = 1'b0;
        nrsp = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge i_clk);
            #1;
            if (o_rsp_valid === 1'b1) nrsp++;
        end
        checks++; if (nrsp != 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d want 0", nrsp); end
        cur_a = 14'h0321; cur_pmr = 2'b01;
        issue(1'b0, 14'h0321, 1'b0, 2'b01, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.lat != RD_LAT || o.data !== fuse_q(14'h0321) || o.err !== 1'b0)
            begin errors++; $display("FAIL rstmid_read got lat=%0d data=%h err=%b want %0d/%h/0", o.lat, o.data, o.err, RD_LAT, fuse_q(14'h0321)); end
    endtask

    task automatic test_pmr;
        obs_t o;
        bit   ok;
        int   bad;
        cur_a = 14'h0555; cur_pmr = 2'b10;
        issue(1'b0, 14'h0555, 1'b0, 2'b10, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.pin_bad != 0 || o.lat != RD_LAT) begin errors++; $display("FAIL pmr_during_op got pin_bad=%0d lat=%0d want 0/%0d", o.pin_bad, o.lat, RD_LAT); end
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge i_clk);
            #1;
            if (o_efuse_pmr !== 2'b10) bad++;
        end
        issue(1'b0, 14'h3FFF, 1'b0, 2'b01, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (bad != 0 || o.pin_bad != 0) begin errors++; $display("FAIL pmr_held got idle_bad=%0d err_cmd_bad=%0d want 0/0", bad, o.pin_bad); end
        cur_a = 14'h0042; cur_pmr = 2'b01;
        issue(1'b0, 14'h0042, 1'b0, 2'b01, ok);
        run_op(cur_a, cur_pmr, o);
        checks++; if (o.pin_bad != 0 || o.data !== fuse_q(14'h0042)) begin errors++; $display("FAIL pmr_relatch got pin_bad=%0d data=%h want 0/%h", o.pin_bad, o.data, fuse_q(14'h0042)); end
    endtask

    task automatic test_random;
        obs_t          o;
        bit            ok;
        logic          prog, unlock, bad;
        logic [AW-1:0] addr;
        logic [1:0]    pmr;
        int            exp_lat, exp_strb;
        logic [39:0]   exp_data;
        for (int i = 0; i < 10; i++) begin
            prog   = ($urandom_range(3) == 0);
            unlock = 1'($urandom_range(1));
            addr   = 14'($urandom_range(16383));
            pmr    = 2'($urandom_range(3));
            if (i == 0) begin prog = 1'b0; addr = 14'(DEPTH - 1); end
            if (i == 1) begin prog = 1'b0; addr = 14'(DEPTH); end
            bad      = (int'(addr) >= DEPTH) || (prog && !unlock);
            exp_lat  = bad ? 1 : (prog ? PG_LAT : RD_LAT);
            exp_strb = bad ? 0 : (prog ? PG : RD);
            exp_data = (bad || prog) ? 40'h0 : fuse_q(addr);
            if (!bad) begin cur_a = addr; cur_pmr = pmr; end
            issue(prog, addr, unlock, pmr, ok);
            run_op(cur_a, cur_pmr, o);
            checks++; if (o.lat != exp_lat || o.err !== bad || o.data !== exp_data)
                begin errors++; $display("FAIL rand[%0d] rsp got lat=%0d err=%b data=%h want %0d/%b/%h", i, o.lat, o.err, o.data, exp_lat, bad, exp_data); end
            checks++; if (o.strb != exp_strb || o.csb_lo != exp_lat - 1 + (bad ? 1 : 0) - (bad ? 1 : 0) - (bad ? exp_lat - 1 : 0))
                begin errors++; $display("FAIL rand[%0d] pins got strb=%0d csb_lo=%0d want %0d/%0d", i, o.strb, o.csb_lo, exp_strb, bad ? 0 : exp_lat - 1); end
            checks++; if (o.viol != 0 || o.pin_bad != 0)
                begin errors++; $display("FAIL rand[%0d] invariants got viol=%0d pin_bad=%0d want 0/0", i, o.viol, o.pin_bad); end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_prog = 1'b0; i_req_addr = '0;
        i_prog_unlock = 1'b0; i_pmr = 2'b00;
        cur_a = '0; cur_pmr = '0;
        test_reset();
        test_read_basic();
        test_program();
        test_errors();
        test_back_to_back();
        test_reset_mid_program();
        test_pmr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/efuse_ctrl.md
Name: efuse_ctrl

Overview:
Sequencer between a single-requester valid/ready command interface and the Samsung LN05LPE 10k x 40b eFUSE macro wrapper. It converts read and program commands into the CSB/LOAD/PGENB/PSM/STROBE timing the macro requires, with cycle counts set by parameters. It captures read data and returns a single response per command. It sits in the always-on/secure domain, one level above the eFUSE wrapper, and below the fuse shadow-register loader and the JTAG/APB program path.

Parameters:
EFUSE_ADDR_W, 14, macro address width
EFUSE_DEPTH, 10240, number of valid addresses; addresses >= EFUSE_DEPTH are rejected
SETUP_CYC, 2, cycles from CSB/LOAD/PGENB/A stable to STROBE rise (>=1)
RD_STRB_CYC, 4, read STROBE high width in cycles (>=1)
PG_STRB_CYC, 200, program STROBE high width in cycles (>=1)
PSM_CYC, 50, cycles PSM is high before program STROBE (power-switch settle, >=1)
HOLD_CYC, 2, cycles after STROBE fall before CSB deasserts (>=1)
CNT_W, 16, timing counter width; must hold max(parameters)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req_valid  in  1  command valid
o_req_ready  out  1  controller can accept a command
i_req_prog  in  1  0 = read word, 1 = program bit
i_req_addr  in  EFUSE_ADDR_W  fuse address
i_prog_unlock  in  1  program enable; sampled at acceptance
i_pmr  in  2  margin-read select, latched at acceptance
o_rsp_valid  out  1  response pulse, one cycle
o_rsp_err  out  1  error flag, qualified by o_rsp_valid
o_rsp_data  out  40  read data, qualified by o_rsp_valid
o_busy  out  1  high whenever state != IDLE
o_efuse_csb, o_efuse_strobe, o_efuse_load, o_efuse_pgenb, o_efuse_psm  out  1 each  macro controls, all registered
o_efuse_a  out  EFUSE_ADDR_W  macro address, registered
o_efuse_pmr  out  2  macro margin select
i_efuse_q  in  40  macro data output

Behaviour:
- Reset values: csb=1, strobe=0, load=1, pgenb=1, psm=0, a=0, pmr=0, o_req_ready=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0, o_busy=0. State is IDLE.
- o_req_ready = (state==IDLE) && !i_rst. This is combinational from the state register. A command is accepted on i_req_valid && o_req_ready.
- Acceptance with addr >= EFUSE_DEPTH, or with prog=1 and i_prog_unlock=0: go to RESP with err=1 and data=0. The macro pins are not touched.
- States and transitions:
  - IDLE: on accept, latch prog/addr/pmr into o_efuse_*. Next state is SETUP (read) or PWRUP (program).
  - PWRUP (program only): csb=0, load=0, psm=1, pgenb=1. Stay PSM_CYC cycles, then SETUP.
  - SETUP: csb=0. Read drives load=1, pgenb=1. Program drives load=0, pgenb=0, psm=1. Stay SETUP_CYC cycles, then STROBE.
  - STROBE: strobe=1 for RD_STRB_CYC or PG_STRB_CYC cycles. In the last read cycle, capture i_efuse_q into the data register. Then HOLD.
  - HOLD: strobe=0, other pins held. Stay HOLD_CYC cycles, then RESP. On HOLD exit: csb=1, load=1, pgenb=1, psm=0.
  - RESP: o_rsp_valid=1 for exactly one cycle. err=0; data = captured word (read) or 0 (program). Then IDLE.
- Counter: loaded with (N-1) on state entry and decremented each cycle; the state exits when it reaches 0. Each state therefore lasts exactly N cycles.
- Latency, accept edge to o_rsp_valid: read = SETUP_CYC+RD_STRB_CYC+HOLD_CYC+1; program adds PSM_CYC and uses PG_STRB_CYC in place of RD_STRB_CYC. Error response = 1 cycle.
- Invariants:
  - pgenb=0 only when load=0, psm=1 and csb=0.
  - strobe=1 only when csb=0.
  - o_efuse_a, load and pgenb never change while strobe=1.
- No back-to-back overlap: the next command is accepted at the earliest in the cycle after RESP.
- i_req_* are ignored while busy. i_prog_unlock changes mid-operation do not abort the operation.
- Synchronous reset in any state returns all outputs to reset values on the next edge. No response is emitted and a partial program is abandoned.

Test Plan:
- Read, defaults, addr=0x0123, macro model Q=0xA5_5A5A_5A5A -> strobe high 4 cycles with load=1/pgenb=1; rsp_valid exactly 9 cycles after accept, data=0xA55A5A5A5A, err=0.
- Program, addr=0x2000, unlock=1 -> psm high 50 cycles before pgenb falls; strobe high 200 cycles; rsp 255 cycles after accept, err=0; check all pin invariants every cycle.
- Program with unlock=0, and read with addr=10240 -> each gets rsp_valid the cycle after accept with err=1, csb stays 1 throughout.
- Back-to-back: i_req_valid held high with 3 reads -> accepts are spaced exactly 10 cycles apart, 3 responses, ready low while busy.
- Reset asserted during program STROBE cycle 100 -> next edge: strobe=0, pgenb=1, psm=0, csb=1, no rsp_valid; a subsequent read completes normally.
- i_pmr=2'b10 on read -> o_efuse_pmr=2'b10 from SETUP through HOLD, returns to the latched value only on the next accept.
